// File: rtl/bus_arbiter_if.sv
// Shared bus bundle between N bus masters, the round-robin arbiter and one slave port.
// Per-master fields are flat packed vectors; slice i of a field belongs to master i.
interface bus_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]    m_valid;
  logic [N*32-1:0] m_address;
  logic [N*4-1:0]  m_wstrobe;
  logic [N*32-1:0] m_wdata;
  logic [N-1:0]    m_ready;
  logic [31:0]     m_rdata;
  logic [N-1:0]    m_irq;

  logic            s_valid;
  logic [31:0]     s_address;
  logic [3:0]      s_wstrobe;
  logic [31:0]     s_wdata;
  logic            s_ready;
  logic [31:0]     s_rdata;
  logic            s_irq;

  logic [N-1:0]    grant;
  logic            busy;

  modport arb (
    input  m_valid, m_address, m_wstrobe, m_wdata,
    output m_ready, m_rdata, m_irq,
    output s_valid, s_address, s_wstrobe, s_wdata,
    input  s_ready, s_rdata, s_irq,
    output grant, busy
  );

  modport master (
    output m_valid, m_address, m_wstrobe, m_wdata,
    input  m_ready, m_rdata, m_irq, grant
  );

  modport slave (
    input  s_valid, s_address, s_wstrobe, s_wdata,
    output s_ready, s_rdata, s_irq
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter locking one slave bus to a master for a whole valid/ready transfer.
// Grant registered one cycle after request; slave wait states stall the owner; one IDLE cycle between transfers.
module bus_arbiter #(
  parameter int N          = 2,
  parameter int IRQ_MASTER = 0
) (
  input  logic      clk,
  input  logic      reset,
  bus_arbiter_if.arb bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t          state;
  logic [IW-1:0]   owner_reg;
  logic [IW-1:0]   last_reg;
  logic [N-1:0]    grant_reg;
  logic            busy_reg;

  logic            pick_vld;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic            own_valid;
  logic [31:0]     own_address;
  logic [3:0]      own_wstrobe;
  logic [31:0]     own_wdata;
  logic            granted;

  // Search starts just past the previous owner so it has lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_reg) + k) % N);
      if (!pick_vld && bus.m_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  assign granted = (state == GRANTED);

  always_comb begin
    own_valid   = 1'b0;
    own_address = '0;
    own_wstrobe = '0;
    own_wdata   = '0;
    for (int i = 0; i < N; i++) begin
      if (granted && owner_reg == IW'(i)) begin
        own_valid   = bus.m_valid[i];
        own_address = bus.m_address[i*32 +: 32];
        own_wstrobe = bus.m_wstrobe[i*4 +: 4];
        own_wdata   = bus.m_wdata[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner_reg <= '0;
      last_reg  <= IW'(N - 1);
      grant_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= GRANTED;
            owner_reg <= pick;
            last_reg  <= pick;
            grant_reg <= {{(N-1){1'b0}}, 1'b1} << pick;
            busy_reg  <= 1'b1;
          end
        end
        GRANTED: begin
          // A dropped request abandons the transfer without a completion.
          if (!own_valid || bus.s_ready) begin
            state     <= IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.m_ready = '0;
    bus.m_irq   = '0;
    for (int i = 0; i < N; i++) begin
      bus.m_ready[i] = granted && (owner_reg == IW'(i)) && own_valid && bus.s_ready;
      bus.m_irq[i]   = (i == IRQ_MASTER) && bus.s_irq;
    end
  end

  assign bus.s_valid   = own_valid;
  assign bus.s_address = own_address;
  assign bus.s_wstrobe = own_wstrobe;
  assign bus.s_wdata   = own_wdata;
  assign bus.m_rdata   = bus.s_rdata;
  assign bus.grant     = grant_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a 2-master instance (irq to master 1) and a 4-master instance.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_arbiter_if #(.N(2)) a_bus ();
  bus_arbiter_if #(.N(4)) b_bus ();

  bus_arbiter #(.N(2), .IRQ_MASTER(1)) dut_a (.clk(clk), .reset(reset), .bus(a_bus));
  bus_arbiter #(.N(4), .IRQ_MASTER(0)) dut_b (.clk(clk), .reset(reset), .bus(b_bus));

  typedef struct {
    int          master;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A completion is expected now: pop the scoreboard and compare owner and read data.
  task automatic observe(input string tag, input logic [7:0] rdy, input logic [31:0] rdata);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(rdy), 32'h0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ready"}, 32'(rdy), 32'(1) << e.master);
      chk({tag, "_rdata"}, rdata, e.rdata);
    end
  endtask

  initial begin
    reset           = 1'b1;
    a_bus.m_valid   = '0;
    a_bus.m_address = '0;
    a_bus.m_wstrobe = '0;
    a_bus.m_wdata   = '0;
    a_bus.s_ready   = 1'b0;
    a_bus.s_rdata   = '0;
    a_bus.s_irq     = 1'b0;
    b_bus.m_valid   = '0;
    b_bus.m_address = '0;
    b_bus.m_wstrobe = '0;
    b_bus.m_wdata   = '0;
    b_bus.s_ready   = 1'b0;
    b_bus.s_rdata   = '0;
    b_bus.s_irq     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_grant_a", 32'(a_bus.grant), 32'h0);
    chk("rst_busy_a", 32'(a_bus.busy), 32'h0);
    chk("rst_svalid_a", 32'(a_bus.s_valid), 32'h0);
    chk("rst_mready_a", 32'(a_bus.m_ready), 32'h0);
    chk("rst_saddr_a", a_bus.s_address, 32'h0);
    chk("rst_grant_b", 32'(b_bus.grant), 32'h0);
    chk("rst_svalid_b", 32'(b_bus.s_valid), 32'h0);
    reset = 1'b0;
    a_bus.s_rdata = 32'h1234_5678;
    #1;
    chk("rdata_follow", a_bus.m_rdata, 32'h1234_5678);
    a_bus.s_rdata = '0;

    // Single master write with two slave wait states
    a_bus.m_valid           = 2'b10;
    a_bus.m_address[63:32]  = 32'h0000_0100;
    a_bus.m_wstrobe[7:4]    = 4'hF;
    a_bus.m_wdata[63:32]    = 32'hDEAD_BEEF;
    #1;
    chk("t1_no_comb_grant", 32'(a_bus.grant), 32'h0);
    tick();
    for (int w = 0; w < 3; w++) begin
      if (w == 2) begin
        a_bus.s_ready = 1'b1;
        a_bus.s_rdata = 32'h0;
        sb.push_back('{1, 32'h0});
      end
      #1;
      chk("t1_grant", 32'(a_bus.grant), 32'h2);
      chk("t1_busy", 32'(a_bus.busy), 32'h1);
      chk("t1_svalid", 32'(a_bus.s_valid), 32'h1);
      chk("t1_saddr", a_bus.s_address, 32'h100);
      chk("t1_sstrb", 32'(a_bus.s_wstrobe), 32'hF);
      chk("t1_swdata", a_bus.s_wdata, 32'hDEAD_BEEF);
      if (w < 2) chk("t1_no_ready", 32'(a_bus.m_ready), 32'h0);
      else       observe("t1_done", 8'(a_bus.m_ready), a_bus.m_rdata);
      tick();
    end
    chk("t1_idle_grant", 32'(a_bus.grant), 32'h0);
    chk("t1_idle_busy", 32'(a_bus.busy), 32'h0);
    chk("t1_idle_ready", 32'(a_bus.m_ready), 32'h0);
    a_bus.s_ready = 1'b0;
    a_bus.m_valid = 2'b00;
    #1;
    chk("t1_idle_svalid", 32'(a_bus.s_valid), 32'h0);
    chk("t1_idle_saddr", a_bus.s_address, 32'h0);

    // Contention after reset, zero-wait slave, both reading
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_bus.m_valid   = 2'b11;
    a_bus.m_address = {32'h0000_0040, 32'h0000_0000};
    a_bus.m_wstrobe = '0;
    a_bus.m_wdata   = '0;
    a_bus.s_ready   = 1'b1;
    sb.push_back('{0, 32'h1111_0000});
    sb.push_back('{1, 32'h2222_0040});
    tick();
    a_bus.s_rdata = 32'h1111_0000;
    #1;
    chk("t2_c1_grant", 32'(a_bus.grant), 32'h1);
    chk("t2_c1_saddr", a_bus.s_address, 32'h0);
    chk("t2_c1_sstrb", 32'(a_bus.s_wstrobe), 32'h0);
    observe("t2_c1", 8'(a_bus.m_ready), a_bus.m_rdata);
    tick();
    a_bus.m_valid = 2'b10;
    #1;
    chk("t2_c2_grant", 32'(a_bus.grant), 32'h0);
    chk("t2_c2_ready", 32'(a_bus.m_ready), 32'h0);
    tick();
    a_bus.s_rdata = 32'h2222_0040;
    #1;
    chk("t2_c3_grant", 32'(a_bus.grant), 32'h2);
    chk("t2_c3_saddr", a_bus.s_address, 32'h40);
    observe("t2_c3", 8'(a_bus.m_ready), a_bus.m_rdata);
    tick();
    a_bus.m_valid = 2'b00;
    a_bus.s_ready = 1'b0;
    #1;
    chk("t2_c4_grant", 32'(a_bus.grant), 32'h0);
    chk("t2_c4_ready", 32'(a_bus.m_ready), 32'h0);
    chk("t2_sb_empty", 32'(sb.size()), 32'h0);

    // Sustained contention on four masters
    b_bus.m_valid = 4'hF;
    b_bus.s_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sb.push_back('{k % 4, 32'hB000_0000 + 32'(k)});
      tick();
      b_bus.s_rdata = 32'hB000_0000 + 32'(k);
      #1;
      chk("t3_grant", 32'(b_bus.grant), 32'(1) << (k % 4));
      chk("t3_busy", 32'(b_bus.busy), 32'h1);
      observe("t3", 8'(b_bus.m_ready), b_bus.m_rdata);
      tick();
      chk("t3_idle_grant", 32'(b_bus.grant), 32'h0);
      chk("t3_idle_ready", 32'(b_bus.m_ready), 32'h0);
    end
    b_bus.m_valid = 4'h0;
    b_bus.s_ready = 1'b0;
    b_bus.s_irq   = 1'b1;
    #1;
    chk("b_irq_on", 32'(b_bus.m_irq), 32'h1);
    b_bus.s_irq = 1'b0;
    #1;
    chk("b_irq_off", 32'(b_bus.m_irq), 32'h0);

    // Owner drops its request before the slave completes
    a_bus.m_valid = 2'b01;
    a_bus.s_ready = 1'b0;
    tick();
    chk("t4_grant", 32'(a_bus.grant), 32'h1);
    chk("t4_svalid", 32'(a_bus.s_valid), 32'h1);
    tick();
    a_bus.m_valid = 2'b00;
    #1;
    chk("t4_drop_svalid", 32'(a_bus.s_valid), 32'h0);
    chk("t4_drop_ready", 32'(a_bus.m_ready), 32'h0);
    chk("t4_drop_grant", 32'(a_bus.grant), 32'h1);
    tick();
    chk("t4_idle_grant", 32'(a_bus.grant), 32'h0);
    chk("t4_idle_busy", 32'(a_bus.busy), 32'h0);
    chk("t4_idle_ready", 32'(a_bus.m_ready), 32'h0);

    // Reset during a wait-stated transfer; irq routing while granted
    a_bus.m_valid = 2'b10;
    tick();
    chk("t5_grant", 32'(a_bus.grant), 32'h2);
    a_bus.s_irq = 1'b1;
    #1;
    chk("t5_irq_on", 32'(a_bus.m_irq), 32'h2);
    tick();
    chk("t5_wait_svalid", 32'(a_bus.s_valid), 32'h1);
    a_bus.s_irq = 1'b0;
    #1;
    chk("t5_irq_off", 32'(a_bus.m_irq), 32'h0);
    reset = 1'b1;
    tick();
    chk("t5_rst_svalid", 32'(a_bus.s_valid), 32'h0);
    chk("t5_rst_grant", 32'(a_bus.grant), 32'h0);
    chk("t5_rst_busy", 32'(a_bus.busy), 32'h0);
    chk("t5_rst_ready", 32'(a_bus.m_ready), 32'h0);
    reset = 1'b0;
    a_bus.m_valid = 2'b11;
    tick();
    chk("t5_rearb_grant", 32'(a_bus.grant), 32'h1);
    a_bus.s_ready = 1'b1;
    a_bus.s_rdata = 32'hC0DE_0000;
    sb.push_back('{0, 32'hC0DE_0000});
    #1;
    observe("t5_done", 8'(a_bus.m_ready), a_bus.m_rdata);
    tick();
    a_bus.m_valid = 2'b00;
    a_bus.s_ready = 1'b0;
    #1;
    chk("t5_end_grant", 32'(a_bus.grant), 32'h0);
    chk("sb_final_empty", 32'(sb.size()), 32'h0);

    // Irq routing in idle
    a_bus.s_irq = 1'b1;
    #1;
    chk("t6_irq_on", 32'(a_bus.m_irq), 32'h2);
    a_bus.s_irq = 1'b0;
    #1;
    chk("t6_irq_off", 32'(a_bus.m_irq), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one slave-side memory bus between N bus masters, e.g. the Virgule core and a DMA or debug master. A registered grant locks the slave bus to one master for a whole valid/ready transfer. Read data is broadcast to every master, and the interrupt line is routed to a single designated master. It sits between the masters' bus ports and the memory/peripheral interconnect.

## Interface
Parameters:
- N, 2: number of masters, legal range 2..8.
- IRQ_MASTER, 0: index of the master that receives s_irq.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- m_valid  in  N  per-master request; held until the matching m_ready.
- m_address  in  N*32  per-master byte address; slice i is bits [32i+31:32i].
- m_wstrobe  in  N*4  per-master byte write strobes; all-zero means read.
- m_wdata  in  N*32  per-master write data.
- m_ready  out  N  per-master completion, one cycle wide.
- m_rdata  out  32  read data, broadcast to all masters.
- m_irq  out  N  interrupt, one-hot at IRQ_MASTER.
- s_valid  out  1  slave request.
- s_address  out  32  slave address.
- s_wstrobe  out  4  slave write strobes.
- s_wdata  out  32  slave write data.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data, valid when s_ready=1.
- s_irq  in  1  slave interrupt.
- grant  out  N  one-hot current owner; zero when idle.
- busy  out  1  1 while in state GRANTED.

## Operation
- States:
  - IDLE: no owner.
  - GRANTED: owner_reg is valid.
- IDLE:
  - If any m_valid is set, select the first requesting index found searching upward from (last_reg+1) mod N, with wrap-around.
  - Register that index in owner_reg and last_reg, then go to GRANTED.
  - If no m_valid is set, stay in IDLE.
- GRANTED, slave-side outputs:
  - s_valid = m_valid[owner_reg].
  - s_address, s_wstrobe and s_wdata are the owner's slices.
- GRANTED, master-side outputs:
  - m_ready[owner_reg] = s_ready.
  - All other m_ready bits are 0.
- GRANTED, transitions:
  - On s_ready=1, return to IDLE.
  - If the owner drops m_valid before s_ready (a protocol violation), return to IDLE at the next edge without completing. s_valid is already 0 in that cycle.
- In IDLE:
  - s_valid=0, and s_address, s_wstrobe, s_wdata are 0.
  - All m_ready bits are 0.
- s_ready in IDLE, or while s_valid=0, is ignored.
- m_rdata = s_rdata combinationally at all times. A master may only sample it when its own m_ready is 1.
- m_irq[IRQ_MASTER] = s_irq combinationally. All other m_irq bits are 0.
- Fairness: the owner of the previous transfer has the lowest priority in the next arbitration. No master waits more than N-1 transfers once its request is asserted.
- grant = one-hot decode of owner_reg in GRANTED, 0 in IDLE.

## Timing
- Reset values:
  - state IDLE, owner_reg=0, last_reg=N-1, so master 0 wins the first contention.
  - All outputs 0, except m_rdata and m_irq, which follow s_rdata and s_irq.
- Arbitration latency:
  - A request seen in IDLE at edge t drives s_valid from cycle t+1.
  - With a zero-wait slave, s_ready=1 in cycle t+1 gives m_ready in cycle t+1.
  - The state is IDLE again in cycle t+2.
- Throughput: at most one transfer per 2 cycles. This is the mandatory IDLE cycle, needed because the completing master still holds m_valid during its m_ready cycle.
- Slave wait states extend GRANTED indefinitely. No timeout.
- Simultaneous new requests arriving during GRANTED are not considered until the next IDLE cycle.
- Reset asserted mid-transfer:
  - Go to IDLE and drop s_valid in the cycle after the reset edge.
  - No m_ready is issued for the aborted transfer.
- All state updates occur on the rising edge of clk. No combinational path from m_valid to grant.

## Test plan
- Single master, N=2, master 1 writes address 0x100, data 0xDEADBEEF, wstrobe 0xF; slave ready after 2 wait cycles -> grant=2'b10 one cycle after request; s_* mirror master 1 for 3 cycles; m_ready=2'b10 for exactly 1 cycle; IDLE on the next cycle.
- Contention after reset, both masters reading (0x0 and 0x40) with a zero-wait slave -> master 0 served first, then master 1; m_ready pulses at cycles 1 and 3; m_rdata equals the s_rdata of each completion.
- Sustained contention, N=4, all masters always requesting -> grant order 0,1,2,3,0,… with one transfer every 2 cycles and no master skipped.
- Owner drops m_valid while s_ready=0 -> s_valid=0 that cycle; next cycle IDLE with grant=0 and no m_ready.
- Reset asserted during a wait-stated transfer -> one cycle later s_valid=0 and grant=0; the next arbitration after reset picks master 0.
- s_irq toggled with IRQ_MASTER=1, N=2 -> m_irq=2'b10 while s_irq=1, else 2'b00, independent of the arbiter state.
